vend_mode_ctrl: RTL and testbench
=================================

# vend_mode_ctrl

Registered top-level mode controller for the vending machine, sitting between the debounced panel inputs and the datapath/display blocks. It runs the customer flow (browse, quantity, payment, result) and the administrator menu. It is generalised over channel count, quantity, money width and admin page count. It adds edge-detected buttons, payment accumulation, change/refund, a sales total and an optional payment timeout.

## Interface
- N_CH, 16: product channels; CH_W = $clog2(N_CH)
- MAX_QTY, 4: max units per purchase; QTY_W = $clog2(MAX_QTY+1)
- MONEY_W, 10: width of price/paid/due/change
- STOCK_W, 8: stock count width
- SALES_W, 16: sales_total width
- SHOW_CYC, 200: result display hold, cycles
- TIMEOUT_CYC, 1000: payment inactivity limit, cycles (timeout build only)

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous, active-high reset
- main_switch, adm_mode  in  1  power and admin levels
- btn_plus, btn_minus, btn_confirm, btn_return  in  1 each  debounced levels
- ch_sel  in  CH_W  selected channel
- unit_price  in  MONEY_W  price of ch_sel
- stock  in  STOCK_W  stock of ch_sel
- coin_valid  in  1  one-cycle coin strobe
- coin_value  in  MONEY_W  coin value
- state_o  out  4  current state code
- qty  out  QTY_W  selected quantity
- due, paid, change  out  MONEY_W  money registers
- vend_valid  out  1  dispense pulse; vend_ch (CH_W) and vend_qty (QTY_W) are valid with it
- restock_valid  out  1  add one unit to ch_sel
- coin_reject  out  1  coin not accepted
- adm_page  out  2  admin menu page
- sales_total  out  SALES_W  accumulated revenue

## Operation
- Button press = level high and previous sample low. Previous-sample registers reset to 0.
- Per-cycle priority:
  - main_switch low forces OFF from any state.
  - In a customer state, adm_mode high enters ADM_MENU with page 0.
  - In an admin state, adm_mode low enters INQUIRE.
  - Otherwise the state rule below applies.
- OFF: main_switch high -> INQUIRE.
- INQUIRE: confirm -> ADD_AMOUNT with qty=1.
- ADD_AMOUNT:
  - plus: qty+1, saturating at min(MAX_QTY, stock).
  - minus: qty-1, saturating at 1.
  - return -> INQUIRE.
  - confirm with stock==0 or stock<qty -> FAILURE.
  - confirm otherwise -> PAYMENT; latch due = unit_price*qty, saturating at all-ones; latch vend_ch = ch_sel.
- PAYMENT:
  - coin_valid adds coin_value to paid, saturating.
  - paid+coin >= due -> SUCCESS. change = paid+coin-due. One-cycle vend_valid. sales_total += due, wrapping.
  - return -> FAILURE with change = paid (refund).
  - Payment completion beats return in the same cycle. A coin arriving with return is included in the refund.
- SUCCESS/FAILURE: hold SHOW_CYC cycles, or until confirm/return -> INQUIRE. On exit, qty, due, paid and change clear.
- ADM_MENU:
  - plus: page+1 mod 3. minus: page-1 mod 3.
  - confirm, page 0 -> ADM_INQUIRE.
  - confirm, page 1 -> ADM_RESET.
  - confirm, page 2 -> ADM_SALES.
- ADM_INQUIRE: confirm -> ADM_ADD; return -> ADM_MENU.
- ADM_ADD: each plus gives a one-cycle restock_valid. return -> ADM_INQUIRE.
- ADM_RESET: clears sales_total on entry cycle; return -> ADM_MENU.
- ADM_SALES: display only; return -> ADM_MENU.
- coin_valid outside PAYMENT is not accumulated; coin_reject pulses the next cycle.
- State codes (4 bits): OFF 0000, INQUIRE 0001, PAYMENT 0010, ADD_AMOUNT 0011, ADM_MENU 0101, SUCCESS 0110, FAILURE 0111, ADM_SALES 1010, ADM_INQUIRE 1101, ADM_RESET 1110, ADM_ADD 1111.

## Timing
- All outputs are registered.
- Reset values: state OFF; every other output 0, including sales_total and adm_page.
- Input to state change: 1 cycle. vend_valid asserts in the first SUCCESS cycle.
- Reset mid-PAYMENT discards paid with no refund pulse. Power-off (main_switch low) in PAYMENT behaves the same way.

## Configuration
- VEND_TIMEOUT_EN defined:
  - An inactivity counter runs in ADD_AMOUNT and PAYMENT.
  - Any press or coin reloads it.
  - Reaching TIMEOUT_CYC -> FAILURE with change = paid.
- VEND_TIMEOUT_EN undefined: no counter is built, these states wait indefinitely, and TIMEOUT_CYC is ignored.

## Structure
- Package vend_pkg holds:
  - the state enum and its encodings
  - the ADM page constants (ADM_PG_INQ=0, ADM_PG_RST=1, ADM_PG_SALES=2)
- Sub-module vend_btn_edge: 4-bit level to press-pulse detector.

## Test plan
- Purchase, exact pay: power on; confirm; plus; unit_price=30, stock=5; confirm; coins 50, 10 -> SUCCESS, due=60, change=0, vend_valid with vend_qty=2, sales_total=60.
- Overpay: due=30; coin 50 -> change=20. Result clears after SHOW_CYC cycles -> INQUIRE.
- Refund: due=40; coin 20, then return -> FAILURE, change=20, no vend_valid.
- Same-cycle events: coin completes due while return is pressed -> SUCCESS. With stock=1, plus in ADD_AMOUNT keeps qty=1. Coin in INQUIRE -> coin_reject.
- Admin: minus from page 0 -> page 2; confirm -> ADM_SALES; return; plus twice to page 1; confirm -> sales_total=0. ADM_ADD with 3 plus presses -> 3 restock_valid pulses.
- Timeout build: enter PAYMENT, hold idle for TIMEOUT_CYC cycles -> FAILURE. main_switch low in PAYMENT -> OFF with all outputs cleared.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending mode controller: state encodings, admin page
// numbers and button bit positions used by the edge detector.
package vend_pkg;

  typedef enum logic [3:0] {
    ST_OFF         = 4'b0000,
    ST_INQUIRE     = 4'b0001,
    ST_PAYMENT     = 4'b0010,
    ST_ADD_AMOUNT  = 4'b0011,
    ST_ADM_MENU    = 4'b0101,
    ST_SUCCESS     = 4'b0110,
    ST_FAILURE     = 4'b0111,
    ST_ADM_SALES   = 4'b1010,
    ST_ADM_INQUIRE = 4'b1101,
    ST_ADM_RESET   = 4'b1110,
    ST_ADM_ADD     = 4'b1111
  } vend_state_e;

  localparam logic [1:0] ADM_PG_INQ   = 2'd0;
  localparam logic [1:0] ADM_PG_RST   = 2'd1;
  localparam logic [1:0] ADM_PG_SALES = 2'd2;

  localparam int BTN_PLUS    = 0;
  localparam int BTN_MINUS   = 1;
  localparam int BTN_CONFIRM = 2;
  localparam int BTN_RETURN  = 3;

  function automatic logic is_customer(vend_state_e s);
    return (s == ST_INQUIRE) || (s == ST_ADD_AMOUNT) || (s == ST_PAYMENT) ||
           (s == ST_SUCCESS) || (s == ST_FAILURE);
  endfunction

  function automatic logic is_admin(vend_state_e s);
    return (s == ST_ADM_MENU) || (s == ST_ADM_INQUIRE) || (s == ST_ADM_ADD) ||
           (s == ST_ADM_RESET) || (s == ST_ADM_SALES);
  endfunction

endpackage

// File: rtl/vend_btn_edge.sv
// Turns four debounced button levels into single-cycle press pulses
// (level high while the previous sample was low).
module vend_btn_edge (
  input  logic       clk,
  input  logic       srst,
  input  logic [3:0] level_i,
  output logic [3:0] press_o
);

  logic [3:0] prev_q;

  always_ff @(posedge clk) begin
    if (srst) prev_q <= '0;
    else      prev_q <= level_i;
  end

  assign press_o = level_i & ~prev_q;

endmodule

// File: rtl/vend_mode_ctrl.sv
// Vending machine mode controller: customer purchase flow and admin menu.
// Define VEND_TIMEOUT_EN to build the inactivity timeout in ADD_AMOUNT/PAYMENT.
module vend_mode_ctrl
  import vend_pkg::*;
#(
  parameter  int N_CH        = 16,
  parameter  int MAX_QTY     = 4,
  parameter  int MONEY_W     = 10,
  parameter  int STOCK_W     = 8,
  parameter  int SALES_W     = 16,
  parameter  int SHOW_CYC    = 200,
  parameter  int TIMEOUT_CYC = 1000,
  localparam int CH_W        = $clog2(N_CH),
  localparam int QTY_W       = $clog2(MAX_QTY + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               main_switch,
  input  logic               adm_mode,
  input  logic               btn_plus,
  input  logic               btn_minus,
  input  logic               btn_confirm,
  input  logic               btn_return,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic [MONEY_W-1:0] unit_price,
  input  logic [STOCK_W-1:0] stock,
  input  logic               coin_valid,
  input  logic [MONEY_W-1:0] coin_value,
  output logic [3:0]         state_o,
  output logic [QTY_W-1:0]   qty,
  output logic [MONEY_W-1:0] due,
  output logic [MONEY_W-1:0] paid,
  output logic [MONEY_W-1:0] change,
  output logic               vend_valid,
  output logic [CH_W-1:0]    vend_ch,
  output logic [QTY_W-1:0]   vend_qty,
  output logic               restock_valid,
  output logic               coin_reject,
  output logic [1:0]         adm_page,
  output logic [SALES_W-1:0] sales_total
);

  localparam int SHOW_W = $clog2(SHOW_CYC + 1);
  localparam int PROD_W = MONEY_W + QTY_W;

  logic [3:0] press;
  logic       p_plus, p_minus, p_conf, p_ret;

  vend_btn_edge u_btn_edge (
    .clk     (clk),
    .srst    (rst_n),
    .level_i ({btn_return, btn_confirm, btn_minus, btn_plus}),
    .press_o (press)
  );

  assign p_plus  = press[BTN_PLUS];
  assign p_minus = press[BTN_MINUS];
  assign p_conf  = press[BTN_CONFIRM];
  assign p_ret   = press[BTN_RETURN];

  vend_state_e        state_q;
  logic [QTY_W-1:0]   qty_q, vend_qty_q;
  logic [MONEY_W-1:0] due_q, paid_q, change_q;
  logic [CH_W-1:0]    vend_ch_q;
  logic               vend_valid_q, restock_q, reject_q;
  logic [1:0]         page_q;
  logic [SALES_W-1:0] sales_q;
  logic [SHOW_W-1:0]  show_cnt_q;

  // Saturating money arithmetic: paid+coin and unit_price*qty clip to all-ones.
  logic [MONEY_W:0]   coin_sum;
  logic [MONEY_W-1:0] paid_plus, paid_in;
  logic [PROD_W-1:0]  due_full;
  logic [MONEY_W-1:0] due_sat;
  logic               can_inc, stock_short;

  assign coin_sum    = {1'b0, paid_q} + {1'b0, coin_value};
  assign paid_plus   = coin_sum[MONEY_W] ? '1 : coin_sum[MONEY_W-1:0];
  assign paid_in     = coin_valid ? paid_plus : paid_q;
  assign due_full    = PROD_W'(unit_price) * PROD_W'(qty_q);
  assign due_sat     = (|due_full[PROD_W-1:MONEY_W]) ? '1 : due_full[MONEY_W-1:0];
  assign can_inc     = (32'(qty_q) < 32'(MAX_QTY)) && (32'(qty_q) < 32'(stock));
  assign stock_short = (stock == '0) || (32'(stock) < 32'(qty_q));

  logic timeout_hit;
`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_q;
  logic            timed_state, activity;

  assign timed_state = (state_q == ST_ADD_AMOUNT) || (state_q == ST_PAYMENT);
  assign activity    = (|press) || coin_valid;
  assign timeout_hit = timed_state && !activity && (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst_n || !timed_state || activity) idle_cnt_q <= '0;
    else                                   idle_cnt_q <= idle_cnt_q + TO_W'(1);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= ST_OFF;
      qty_q        <= '0;
      due_q        <= '0;
      paid_q       <= '0;
      change_q     <= '0;
      vend_valid_q <= 1'b0;
      vend_ch_q    <= '0;
      vend_qty_q   <= '0;
      restock_q    <= 1'b0;
      reject_q     <= 1'b0;
      page_q       <= ADM_PG_INQ;
      sales_q      <= '0;
      show_cnt_q   <= '0;
    end else begin
      vend_valid_q <= 1'b0;
      restock_q    <= 1'b0;
      reject_q     <= coin_valid;  // cleared below only where the coin is accepted
      show_cnt_q   <= '0;
      if (!main_switch) begin
        state_q    <= ST_OFF;
        qty_q      <= '0;
        due_q      <= '0;
        paid_q     <= '0;
        change_q   <= '0;
        vend_ch_q  <= '0;
        vend_qty_q <= '0;
        page_q     <= ADM_PG_INQ;
        sales_q    <= '0;
      end else if (is_customer(state_q) && adm_mode) begin
        state_q  <= ST_ADM_MENU;
        page_q   <= ADM_PG_INQ;
        qty_q    <= '0;
        due_q    <= '0;
        paid_q   <= '0;
        change_q <= '0;
      end else if (is_admin(state_q) && !adm_mode) begin
        state_q <= ST_INQUIRE;
      end else begin
        case (state_q)
          ST_OFF: state_q <= ST_INQUIRE;
          ST_INQUIRE: begin
            if (p_conf) begin
              state_q <= ST_ADD_AMOUNT;
              qty_q   <= QTY_W'(1);
            end
          end
          ST_ADD_AMOUNT: begin
            if (p_ret) begin
              state_q <= ST_INQUIRE;
              qty_q   <= '0;
            end else if (p_conf) begin
              if (stock_short) begin
                state_q <= ST_FAILURE;
              end else begin
                state_q   <= ST_PAYMENT;
                due_q     <= due_sat;
                vend_ch_q <= ch_sel;
              end
            end else if (p_plus) begin
              if (can_inc) qty_q <= qty_q + QTY_W'(1);
            end else if (p_minus) begin
              if (qty_q > QTY_W'(1)) qty_q <= qty_q - QTY_W'(1);
            end else if (timeout_hit) begin
              state_q  <= ST_FAILURE;
              change_q <= paid_q;
            end
          end
          ST_PAYMENT: begin
            reject_q <= 1'b0;
            // Completion wins over a simultaneous return; a coin with return is refunded.
            if (coin_valid && (paid_plus >= due_q)) begin
              state_q      <= ST_SUCCESS;
              paid_q       <= paid_plus;
              change_q     <= paid_plus - due_q;
              vend_valid_q <= 1'b1;
              vend_qty_q   <= qty_q;
              sales_q      <= sales_q + SALES_W'(due_q);
            end else if (p_ret) begin
              state_q  <= ST_FAILURE;
              paid_q   <= paid_in;
              change_q <= paid_in;
            end else if (coin_valid) begin
              paid_q <= paid_plus;
            end else if (timeout_hit) begin
              state_q  <= ST_FAILURE;
              change_q <= paid_q;
            end
          end
          ST_SUCCESS, ST_FAILURE: begin
            if (p_conf || p_ret || (show_cnt_q == SHOW_W'(SHOW_CYC - 1))) begin
              state_q  <= ST_INQUIRE;
              qty_q    <= '0;
              due_q    <= '0;
              paid_q   <= '0;
              change_q <= '0;
            end else begin
              show_cnt_q <= show_cnt_q + SHOW_W'(1);
            end
          end
          ST_ADM_MENU: begin
            if (p_conf) begin
              case (page_q)
                ADM_PG_INQ: state_q <= ST_ADM_INQUIRE;
                ADM_PG_RST: begin
                  state_q <= ST_ADM_RESET;
                  sales_q <= '0;
                end
                ADM_PG_SALES: state_q <= ST_ADM_SALES;
                default: state_q <= ST_ADM_MENU;
              endcase
            end else if (p_plus) begin
              page_q <= (page_q == ADM_PG_SALES) ? ADM_PG_INQ : page_q + 2'd1;
            end else if (p_minus) begin
              page_q <= (page_q == ADM_PG_INQ) ? ADM_PG_SALES : page_q - 2'd1;
            end
          end
          ST_ADM_INQUIRE: begin
            if (p_ret)       state_q <= ST_ADM_MENU;
            else if (p_conf) state_q <= ST_ADM_ADD;
          end
          ST_ADM_ADD: begin
            restock_q <= p_plus;
            if (p_ret) state_q <= ST_ADM_INQUIRE;
          end
          ST_ADM_RESET, ST_ADM_SALES: begin
            if (p_ret) state_q <= ST_ADM_MENU;
          end
          default: state_q <= ST_OFF;
        endcase
      end
    end
  end

  assign state_o       = state_q;
  assign qty           = qty_q;
  assign due           = due_q;
  assign paid          = paid_q;
  assign change        = change_q;
  assign vend_valid    = vend_valid_q;
  assign vend_ch       = vend_ch_q;
  assign vend_qty      = vend_qty_q;
  assign restock_valid = restock_q;
  assign coin_reject   = reject_q;
  assign adm_page      = page_q;
  assign sales_total   = sales_q;

endmodule

// File: tb/tb_vend_mode_ctrl.sv
// Bench for vend_mode_ctrl: directed purchase/admin scenarios followed by
// random panel activity, all checked every cycle against a behavioural model.
module tb_vend_mode_ctrl;

  localparam int N_CH = 16, MAX_QTY = 4, MONEY_W = 10, STOCK_W = 8, SALES_W = 16;
  localparam int SHOW_CYC = 12, TIMEOUT_CYC = 40;
  localparam int CH_W = 4, QTY_W = 3;
  localparam int MONEY_MAX = 1023, SALES_MOD = 65536;
  localparam int ST_OFF = 0, ST_INQ = 1, ST_PAY = 2, ST_ADD = 3, ST_MENU = 5, ST_SUC = 6,
                 ST_FAIL = 7, ST_SALES = 10, ST_AINQ = 13, ST_ARST = 14, ST_AADD = 15;

  logic clk = 1'b0;
  logic rst, main_switch, adm_mode;
  logic btn_plus, btn_minus, btn_confirm, btn_return;
  logic [CH_W-1:0] ch_sel;
  logic [MONEY_W-1:0] unit_price, coin_value;
  logic [STOCK_W-1:0] stock;
  logic coin_valid;
  logic [3:0] state_o;
  logic [QTY_W-1:0] qty, vend_qty;
  logic [MONEY_W-1:0] due, paid, change;
  logic vend_valid, restock_valid, coin_reject;
  logic [CH_W-1:0] vend_ch;
  logic [1:0] adm_page;
  logic [SALES_W-1:0] sales_total;

  vend_mode_ctrl #(
    .N_CH(N_CH), .MAX_QTY(MAX_QTY), .MONEY_W(MONEY_W), .STOCK_W(STOCK_W),
    .SALES_W(SALES_W), .SHOW_CYC(SHOW_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst), .main_switch(main_switch), .adm_mode(adm_mode),
    .btn_plus(btn_plus), .btn_minus(btn_minus), .btn_confirm(btn_confirm),
    .btn_return(btn_return), .ch_sel(ch_sel), .unit_price(unit_price), .stock(stock),
    .coin_valid(coin_valid), .coin_value(coin_value), .state_o(state_o), .qty(qty),
    .due(due), .paid(paid), .change(change), .vend_valid(vend_valid), .vend_ch(vend_ch),
    .vend_qty(vend_qty), .restock_valid(restock_valid), .coin_reject(coin_reject),
    .adm_page(adm_page), .sales_total(sales_total)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, rv_seen = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: spec rules on plain integers.
  int m_state, m_qty, m_due, m_paid, m_change, m_vv, m_vch, m_vqty, m_rv, m_rej;
  int m_page, m_sales, m_hold, m_idle;
  bit [3:0] m_prev;

  function automatic bit is_cust(input int s);
    return s == ST_INQ || s == ST_ADD || s == ST_PAY || s == ST_SUC || s == ST_FAIL;
  endfunction

  function automatic bit is_adm(input int s);
    return s == ST_MENU || s == ST_AINQ || s == ST_AADD || s == ST_ARST || s == ST_SALES;
  endfunction

  task automatic model_clear();
    m_state = ST_OFF; m_qty = 0; m_due = 0; m_paid = 0; m_change = 0; m_vv = 0;
    m_vch = 0; m_vqty = 0; m_rv = 0; m_page = 0; m_sales = 0; m_hold = 0;
  endtask

  task automatic enter_result(input int s);
    m_state = s;
    m_hold = 1;
  endtask

  task automatic model_step();
    bit pp, pm, pc, pr, act, fire;
    int sum, d, lim;
    if (rst) begin
      model_clear(); m_rej = 0; m_prev = 0; m_idle = 0;
      return;
    end
    pp = btn_plus && !m_prev[0];
    pm = btn_minus && !m_prev[1];
    pc = btn_confirm && !m_prev[2];
    pr = btn_return && !m_prev[3];
    m_prev = {btn_return, btn_confirm, btn_minus, btn_plus};
    act = pp || pm || pc || pr || coin_valid;
    if ((m_state == ST_ADD || m_state == ST_PAY) && !act) m_idle++;
    else m_idle = 0;
    fire = 1'b0;
`ifdef VEND_TIMEOUT_EN
    fire = (m_idle >= TIMEOUT_CYC);
`endif
    m_vv = 0; m_rv = 0; m_rej = coin_valid;
    sum = m_paid + (coin_valid ? int'(coin_value) : 0);
    if (sum > MONEY_MAX) sum = MONEY_MAX;
    if (!main_switch) model_clear();
    else if (is_cust(m_state) && adm_mode) begin
      m_state = ST_MENU; m_page = 0; m_qty = 0; m_due = 0; m_paid = 0; m_change = 0;
    end else if (is_adm(m_state) && !adm_mode) m_state = ST_INQ;
    else begin
      case (m_state)
        ST_OFF: m_state = ST_INQ;
        ST_INQ: if (pc) begin m_state = ST_ADD; m_qty = 1; end
        ST_ADD: begin
          lim = (int'(stock) < MAX_QTY) ? int'(stock) : MAX_QTY;
          if (pr) begin m_state = ST_INQ; m_qty = 0; end
          else if (pc) begin
            if (stock == 0 || int'(stock) < m_qty) enter_result(ST_FAIL);
            else begin
              d = int'(unit_price) * m_qty;
              m_due = (d > MONEY_MAX) ? MONEY_MAX : d;
              m_vch = int'(ch_sel);
              m_state = ST_PAY;
            end
          end else if (pp) begin if (m_qty < lim) m_qty++; end
          else if (pm) begin if (m_qty > 1) m_qty--; end
          else if (fire) begin enter_result(ST_FAIL); m_change = m_paid; end
        end
        ST_PAY: begin
          m_rej = 0;
          if (coin_valid && sum >= m_due) begin
            enter_result(ST_SUC);
            m_paid = sum; m_change = sum - m_due; m_vv = 1; m_vqty = m_qty;
            m_sales = (m_sales + m_due) % SALES_MOD;
          end else if (pr) begin
            enter_result(ST_FAIL); m_paid = sum; m_change = sum;
          end else if (coin_valid) m_paid = sum;
          else if (fire) begin enter_result(ST_FAIL); m_change = m_paid; end
        end
        ST_SUC, ST_FAIL: begin
          if (pc || pr || m_hold >= SHOW_CYC) begin
            m_state = ST_INQ; m_qty = 0; m_due = 0; m_paid = 0; m_change = 0;
          end else m_hold++;
        end
        ST_MENU: begin
          if (pc) m_state = (m_page == 0) ? ST_AINQ : (m_page == 1) ? ST_ARST : ST_SALES;
          else if (pp) m_page = (m_page + 1) % 3;
          else if (pm) m_page = (m_page + 2) % 3;
          if (m_state == ST_ARST) m_sales = 0;
        end
        ST_AINQ: begin
          if (pr) m_state = ST_MENU;
          else if (pc) m_state = ST_AADD;
        end
        ST_AADD: begin
          m_rv = pp;
          if (pr) m_state = ST_AINQ;
        end
        ST_ARST, ST_SALES: if (pr) m_state = ST_MENU;
        default: m_state = ST_OFF;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("state", state_o, m_state);
    chk("qty", qty, m_qty);
    chk("due", due, m_due);
    chk("paid", paid, m_paid);
    chk("change", change, m_change);
    chk("vend_valid", vend_valid, m_vv);
    chk("vend_ch", vend_ch, m_vch);
    chk("vend_qty", vend_qty, m_vqty);
    chk("restock_valid", restock_valid, m_rv);
    chk("coin_reject", coin_reject, m_rej);
    chk("adm_page", adm_page, m_page);
    chk("sales_total", sales_total, m_sales);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    rv_seen += int'(restock_valid);
    compare_all();
  endtask

  task automatic set_btn(input int b, input bit v);
    case (b)
      0: btn_plus = v;
      1: btn_minus = v;
      2: btn_confirm = v;
      default: btn_return = v;
    endcase
  endtask

  task automatic push(input int b);
    set_btn(b, 1'b1); tick();
    set_btn(b, 1'b0); tick();
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1; coin_value = MONEY_W'(v); tick();
    coin_valid = 1'b0; tick();
  endtask

  localparam int B_PLUS = 0, B_MINUS = 1, B_CONF = 2, B_RET = 3;

  initial begin
    int r, b;
    rst = 1'b1; main_switch = 1'b0; adm_mode = 1'b0;
    btn_plus = 0; btn_minus = 0; btn_confirm = 0; btn_return = 0;
    ch_sel = 4'd3; unit_price = 30; stock = 5; coin_valid = 0; coin_value = 0;
    m_prev = 0; m_idle = 0; m_rej = 0; model_clear();
    tick(); tick();
    chk("reset_state", state_o, ST_OFF);
    chk("reset_sales", sales_total, 0);
    rst = 1'b0; main_switch = 1'b1;
    tick();
    chk("power_on", state_o, ST_INQ);

    // Exact payment, qty 2 at 30.
    push(B_CONF); push(B_PLUS); push(B_CONF);
    chk("tp1_due", due, 60);
    coin(50);
    coin_valid = 1'b1; coin_value = 10; tick();
    chk("tp1_state", state_o, ST_SUC);
    chk("tp1_vend", vend_valid, 1);
    chk("tp1_vqty", vend_qty, 2);
    chk("tp1_vch", vend_ch, 3);
    chk("tp1_change", change, 0);
    chk("tp1_sales", sales_total, 60);
    coin_valid = 1'b0;
    push(B_RET);
    chk("tp1_exit", state_o, ST_INQ);

    // Overpay then timed exit from the result display.
    push(B_CONF); push(B_CONF);
    coin_valid = 1'b1; coin_value = 50; tick(); coin_valid = 1'b0;
    chk("tp2_change", change, 20);
    repeat (SHOW_CYC - 1) tick();
    chk("tp2_hold", state_o, ST_SUC);
    tick();
    chk("tp2_expire", state_o, ST_INQ);
    chk("tp2_clear", change, 0);

    // Refund.
    unit_price = 40;
    push(B_CONF); push(B_CONF); coin(20);
    btn_return = 1'b1; tick();
    chk("tp3_state", state_o, ST_FAIL);
    chk("tp3_change", change, 20);
    chk("tp3_novend", vend_valid, 0);
    btn_return = 1'b0; tick(); push(B_CONF);

    // Completing coin together with return.
    push(B_CONF); push(B_CONF);
    coin_valid = 1'b1; coin_value = 40; btn_return = 1'b1; tick();
    chk("tp4_win", state_o, ST_SUC);
    coin_valid = 1'b0; btn_return = 1'b0; tick(); push(B_CONF);

    // Quantity limited by stock, coin outside payment.
    stock = 1;
    push(B_CONF); push(B_PLUS);
    chk("tp5_qty_sat", qty, 1);
    push(B_RET); stock = 5;
    coin_valid = 1'b1; coin_value = 10; tick(); coin_valid = 1'b0;
    chk("tp5_reject", coin_reject, 1);

    // Due saturation.
    unit_price = 600;
    push(B_CONF); push(B_PLUS); push(B_CONF);
    chk("tp6_due_sat", due, MONEY_MAX);
    push(B_RET); push(B_CONF);

    // Admin menu.
    adm_mode = 1'b1; tick();
    chk("adm_enter", state_o, ST_MENU);
    push(B_MINUS);
    chk("adm_wrap", adm_page, 2);
    push(B_CONF);
    chk("adm_sales", state_o, ST_SALES);
    push(B_RET); push(B_PLUS); push(B_PLUS);
    chk("adm_page1", adm_page, 1);
    push(B_CONF);
    chk("adm_reset", sales_total, 0);
    chk("adm_rst_state", state_o, ST_ARST);
    push(B_RET); push(B_MINUS); push(B_CONF); push(B_CONF);
    chk("adm_add", state_o, ST_AADD);
    rv_seen = 0;
    repeat (3) push(B_PLUS);
    chk("adm_restock_cnt", rv_seen, 3);
    adm_mode = 1'b0; tick();
    chk("adm_exit", state_o, ST_INQ);

    // Power-off during payment.
    unit_price = 40;
    push(B_CONF); push(B_CONF); coin(10);
    main_switch = 1'b0; tick();
    chk("off_state", state_o, ST_OFF);
    chk("off_paid", paid, 0);
    chk("off_due", due, 0);
    main_switch = 1'b1; tick();

`ifdef VEND_TIMEOUT_EN
    push(B_CONF); push(B_CONF);
    repeat (TIMEOUT_CYC - 2) tick();
    chk("to_hold", state_o, ST_PAY);
    tick();
    chk("to_fire", state_o, ST_FAIL);
    push(B_CONF);
`endif

    // Random panel activity.
    for (int c = 0; c < 2500; c++) begin
      if (c % 60 == 0) begin
        unit_price = ($urandom_range(3) == 0) ? MONEY_W'($urandom_range(1023))
                                              : MONEY_W'(5 * $urandom_range(1, 20));
        stock  = ($urandom_range(7) == 0) ? 8'd255 : STOCK_W'($urandom_range(6));
        ch_sel = CH_W'($urandom_range(15));
      end
      r = int'($urandom_range(99));
      if (r < 22) begin
        b = int'($urandom_range(3));
        btn_plus = 0; btn_minus = 0; btn_confirm = 0; btn_return = 0;
        set_btn(b, 1'b1);
      end else if (r >= 35) begin
        btn_plus = 0; btn_minus = 0; btn_confirm = 0; btn_return = 0;
      end
      coin_valid = ($urandom_range(9) == 0);
      case ($urandom_range(4))
        0: coin_value = 5;
        1: coin_value = 10;
        2: coin_value = 20;
        3: coin_value = 50;
        default: coin_value = MONEY_W'($urandom_range(1023));
      endcase
      main_switch = ($urandom_range(299) != 0);
      if ($urandom_range(149) == 0) adm_mode = ~adm_mode;
      rst = ($urandom_range(799) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
